seqdet_stream_ctrl: RTL and testbench
=====================================

Name: seqdet_stream_ctrl

Overview:
- Sequencer and matcher for the serial pattern-detector datapath.
- Accepts parallel words from an upstream source over a valid/ready handshake and serializes them MSB-first into a one-bit stream, one bit per clock.
- Runs a programmable PAT_W-bit pattern match on that stream, with overlapping or non-overlapping match mode.
- Counts matches over a job of a programmed number of words and signals completion to the host.

Parameters:
DATA_W, 8, width of input words / bits serialized per word
PAT_W, 5, pattern length in bits (2..DATA_W*2)
CNT_W, 8, width of match counter (saturating)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
start  input  1  begin job (sampled in IDLE only)
abort  input  1  cancel job in FETCH/SHIFT
cfg_pattern  input  PAT_W  pattern; MSB is the earliest bit; latched on start
cfg_overlap  input  1  1 = overlapping matches allowed; latched on start
cfg_words  input  8  number of words in job; latched on start
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  block accepts word
bit_out  output  1  serialized bit currently presented
bit_valid  output  1  bit_out valid (high in SHIFT)
match  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in current/last job
busy  output  1  state != IDLE
done  output  1  one-cycle job-complete pulse
state  output  2  FSM state (IDLE=0, FETCH=1, SHIFT=2, DONE=3)

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, in_ready=0, bit_out=0, bit_valid=0, match=0, match_count=0, busy=0, done=0; history, fill count, word/bit counters cleared. Reset overrides every other input and applies mid-job.
- IDLE:
  - start=1 latches cfg_*, clears match_count, history and fill count.
  - Next state is FETCH, or DONE if cfg_words=0.
  - start outside IDLE is ignored.
- FETCH:
  - in_ready=1 (combinational from state).
  - On in_valid & in_ready: load shift register with in_data, bit index = DATA_W-1, go to SHIFT.
  - No handshake: stay in FETCH. History is unchanged; bubbles do not break a pattern.
- SHIFT:
  - bit_valid=1; bit_out = shift register MSB. One bit per cycle for exactly DATA_W cycles.
  - Each cycle: history <= {history[PAT_W-2:0], bit}; fill count increments, saturating at PAT_W.
  - After the last bit, words_left decrements. Go to DONE if it reaches 0, else FETCH.
  - Consequence: one bubble cycle minimum between words.
- Match rule:
  - A match occurs when the updated history equals the latched pattern and the updated fill count is >= PAT_W.
  - match is registered: high exactly in the cycle after the SHIFT cycle that presented the completing bit.
  - match_count increments in the same cycle as match and saturates at 2^CNT_W-1.
  - Non-overlap mode: the fill count resets to 0 on a match, so the next match needs PAT_W fresh bits.
  - Overlap mode: the fill count is kept.
- Patterns span word boundaries. History is cleared only at start and reset.
- DONE: done=1 for one cycle, then IDLE. A match from the last bit coincides with done.
- abort=1 in FETCH/SHIFT: next state IDLE; no done; no further match; match_count holds. abort takes priority over a same-cycle handshake.
- match_count holds after a job until the next start.

Test Plan:
- Pattern 5'b11111, overlap=1, words=1, in_data=8'hFF always valid:
  - match after bits 5,6,7,8.
  - match_count=4; done 1 cycle after the 8th SHIFT cycle, concurrent with the 4th match.
- Same stimulus with overlap=0:
  - single match after bit 5; match_count=1.
- Pattern 5'b10110, overlap=1, words=2, data 8'h05 then 8'hA0, start at cycle 0:
  - handshakes at cycles 1 and 10; SHIFT cycles 2-9 and 11-18.
  - match only at cycle 13; done at cycle 19; match_count=1.
- Backpressure: in_valid low for 3 cycles between words of the previous case:
  - FETCH held 3 extra cycles with bit_valid=0.
  - Same single cross-boundary match; done 3 cycles later.
- cfg_words=0 with start:
  - DONE in the next cycle, done pulse, in_ready never high, match_count=0.
- Mid-job events:
  - abort during SHIFT of word 1: IDLE next cycle, done never asserted, match_count holds.
  - rst=0 mid-job: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/seqdet_stream_ctrl.sv
// Word-to-bit serializer with a programmable pattern matcher and per-job match counter.
// The host programs a job on start; upstream words are serialized MSB-first, one bit per clock.
module seqdet_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [7:0]        cfg_words,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            st;
    logic [DATA_W-1:0] sreg;
    logic [BIT_W-1:0]  bit_idx;
    logic [7:0]        words_left;
    logic [PAT_W-1:0]  pat_q;
    logic              overlap_q;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic              match_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              cur_bit;
    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              hit;

    // Match is judged on the history and fill count as they will be after this bit.
    always_comb begin
        cur_bit = sreg[DATA_W-1];
        hist_n  = {hist[PAT_W-2:0], cur_bit};
        fill_n  = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        hit     = (st == SHIFT) && (fill_n == FILL_W'(PAT_W)) && (hist_n == pat_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= IDLE;
            sreg       <= '0;
            bit_idx    <= '0;
            words_left <= '0;
            pat_q      <= '0;
            overlap_q  <= 1'b0;
            hist       <= '0;
            fill       <= '0;
            match_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            match_q <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        pat_q      <= cfg_pattern;
                        overlap_q  <= cfg_overlap;
                        words_left <= cfg_words;
                        cnt_q      <= '0;
                        hist       <= '0;
                        fill       <= '0;
                        st         <= (cfg_words == 8'd0) ? DONE : FETCH;
                    end
                end
                // Handshake: a word transfers in any cycle where in_valid and in_ready are both high;
                // in_ready is high exactly in FETCH, and abort wins over a same-cycle transfer.
                FETCH: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (in_valid) begin
                        sreg    <= in_data;
                        bit_idx <= BIT_W'(DATA_W - 1);
                        st      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        st <= IDLE;
                    end else begin
                        hist <= hist_n;
                        fill <= (hit && !overlap_q) ? '0 : fill_n;
                        if (hit) begin
                            match_q <= 1'b1;
                            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        end
                        sreg <= sreg << 1;
                        if (bit_idx == '0) begin
                            words_left <= words_left - 8'd1;
                            st         <= (words_left == 8'd1) ? DONE : FETCH;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                DONE:    st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    assign state       = st;
    assign busy        = (st != IDLE);
    assign done        = (st == DONE);
    assign in_ready    = (st == FETCH);
    assign bit_valid   = (st == SHIFT);
    assign bit_out     = (st == SHIFT) & sreg[DATA_W-1];
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Directed bench for seqdet_stream_ctrl: per-cycle traces of each job compared with hand-derived masks.
// Cycle 0 is the cycle in which start is presented; cycle n is the interval after the n-th following edge.
module tb_seqdet_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] cfg_pattern;
    logic       cfg_overlap;
    logic [7:0] cfg_words;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] match_m, done_m, bv_m, ir_m, bo_m, busy_m;
    logic [1:0]  st_tr[0:63];
    logic [7:0]  cnt_tr[0:63];
    int          done_seen, n_match;
    logic [7:0]  last_cnt;

    seqdet_stream_ctrl #(.DATA_W(8), .PAT_W(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_words(cfg_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
        .match_count(match_count), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Drives one job and records per-cycle outputs; the word driver advances on observed handshakes.
    task automatic run_job(input logic [4:0] pat, input logic ovl, input logic [7:0] nw,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int gap_lo, input int gap_n, input int abort_cyc,
                           input int rst_cyc, input int restart_cyc, input int ncyc);
        int   widx;
        logic hs;
        widx = 0;
        match_m = '0; done_m = '0; bv_m = '0; ir_m = '0; bo_m = '0; busy_m = '0;
        done_seen = 0; n_match = 0;
        for (int i = 0; i < 64; i++) begin
            st_tr[i] = 2'd0;
            cnt_tr[i] = 8'd0;
        end
        cfg_pattern = pat;
        cfg_overlap = ovl;
        cfg_words   = nw;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == restart_cyc);
            if (c == restart_cyc) begin
                cfg_words   = 8'd0;
                cfg_pattern = ~pat;
            end
            abort    = (c == abort_cyc);
            rst      = (c == rst_cyc) ? 1'b0 : 1'b1;
            in_valid = (c >= gap_lo && c < gap_lo + gap_n) ? 1'b0 : 1'b1;
            in_data  = (widx == 0) ? d0 : d1;
            #1;
            if (c < 64) begin
                match_m[c] = match;
                done_m[c]  = done;
                bv_m[c]    = bit_valid;
                ir_m[c]    = in_ready;
                bo_m[c]    = bit_out & bit_valid;
                busy_m[c]  = busy;
                st_tr[c]   = state;
                cnt_tr[c]  = match_count;
            end
            done_seen += int'(done);
            n_match   += int'(match);
            last_cnt   = match_count;
            hs = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (hs) widx++;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cfg_pattern = 5'd0; cfg_overlap = 1'b0; cfg_words = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({state, in_ready, bit_out, bit_valid, match, match_count, busy, done} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got state=%0d rdy=%b bo=%b bv=%b m=%b cnt=%0d busy=%b done=%b, want all 0",
                     state, in_ready, bit_out, bit_valid, match, match_count, busy, done);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overlap_ones;
        run_job(5'b11111, 1'b1, 8'd1, 8'hFF, 8'hFF, -1, 0, -1, -1, -1, 14);
        tests_run++;
        if (match_m !== 64'h780) begin
            tests_failed++; $display("FAIL ovl_match_cycles: got %h want %h", match_m, 64'h780);
        end
        tests_run++;
        if (done_m !== 64'h400) begin
            tests_failed++; $display("FAIL ovl_done_cycle: got %h want %h", done_m, 64'h400);
        end
        tests_run++;
        if (cnt_tr[13] !== 8'd4) begin
            tests_failed++; $display("FAIL ovl_count: got %0d want 4", cnt_tr[13]);
        end
    endtask

    task automatic test_nonoverlap_ones;
        run_job(5'b11111, 1'b0, 8'd1, 8'hFF, 8'hFF, -1, 0, -1, -1, -1, 14);
        tests_run++;
        if (match_m !== 64'h80) begin
            tests_failed++; $display("FAIL novl_match_cycles: got %h want %h", match_m, 64'h80);
        end
        tests_run++;
        if (cnt_tr[13] !== 8'd1 || done_m !== 64'h400) begin
            tests_failed++;
            $display("FAIL novl_count_done: got cnt=%0d done=%h want cnt=1 done=%h", cnt_tr[13], done_m, 64'h400);
        end
    endtask

    // Start re-asserted in SHIFT at cycle 5 with a different config must be ignored.
    task automatic test_cross_boundary;
        run_job(5'b10110, 1'b1, 8'd2, 8'h05, 8'hA0, -1, 0, -1, -1, 5, 22);
        tests_run++;
        if (match_m !== 64'h2000) begin
            tests_failed++; $display("FAIL xb_match_cycles: got %h want %h", match_m, 64'h2000);
        end
        tests_run++;
        if (done_m !== 64'h80000) begin
            tests_failed++; $display("FAIL xb_done_cycle: got %h want %h", done_m, 64'h80000);
        end
        tests_run++;
        if (bv_m !== 64'h7FBFC || ir_m !== 64'h402) begin
            tests_failed++;
            $display("FAIL xb_valid_ready: got bv=%h rdy=%h want bv=%h rdy=%h", bv_m, ir_m, 64'h7FBFC, 64'h402);
        end
        tests_run++;
        if (bo_m !== 64'h2A80) begin
            tests_failed++; $display("FAIL xb_bit_stream: got %h want %h", bo_m, 64'h2A80);
        end
        tests_run++;
        if (cnt_tr[21] !== 8'd1) begin
            tests_failed++; $display("FAIL xb_count: got %0d want 1", cnt_tr[21]);
        end
    endtask

    task automatic test_backpressure;
        run_job(5'b10110, 1'b1, 8'd2, 8'h05, 8'hA0, 10, 3, -1, -1, -1, 26);
        tests_run++;
        if (match_m !== 64'h10000 || done_m !== 64'h400000) begin
            tests_failed++;
            $display("FAIL bp_match_done: got m=%h d=%h want m=%h d=%h", match_m, done_m, 64'h10000, 64'h400000);
        end
        tests_run++;
        if (bv_m !== 64'h3FC3FC || ir_m !== 64'h3C02) begin
            tests_failed++;
            $display("FAIL bp_valid_ready: got bv=%h rdy=%h want bv=%h rdy=%h", bv_m, ir_m, 64'h3FC3FC, 64'h3C02);
        end
        tests_run++;
        if (bo_m !== 64'h14280 || cnt_tr[25] !== 8'd1) begin
            tests_failed++;
            $display("FAIL bp_stream_count: got bo=%h cnt=%0d want bo=%h cnt=1", bo_m, cnt_tr[25], 64'h14280);
        end
    endtask

    task automatic test_zero_words;
        run_job(5'b10101, 1'b1, 8'd0, 8'hFF, 8'hFF, -1, 0, -1, -1, -1, 4);
        tests_run++;
        if (done_m !== 64'h2 || st_tr[1] !== 2'd3 || busy_m !== 64'h2) begin
            tests_failed++;
            $display("FAIL zero_done: got done=%h st1=%0d busy=%h want done=2 st1=3 busy=2", done_m, st_tr[1], busy_m);
        end
        tests_run++;
        if (ir_m !== 64'h0 || cnt_tr[1] !== 8'd0 || match_m !== 64'h0) begin
            tests_failed++;
            $display("FAIL zero_idle_path: got rdy=%h cnt=%0d m=%h want 0 0 0", ir_m, cnt_tr[1], match_m);
        end
    endtask

    task automatic test_abort;
        run_job(5'b11111, 1'b1, 8'd2, 8'hFF, 8'hFF, -1, 0, 7, -1, -1, 14);
        tests_run++;
        if (st_tr[8] !== 2'd0 || bv_m !== 64'hFC) begin
            tests_failed++;
            $display("FAIL abort_state: got st8=%0d bv=%h want st8=0 bv=fc", st_tr[8], bv_m);
        end
        tests_run++;
        if (match_m !== 64'h80 || done_m !== 64'h0 || cnt_tr[13] !== 8'd1) begin
            tests_failed++;
            $display("FAIL abort_effects: got m=%h d=%h cnt=%0d want m=80 d=0 cnt=1", match_m, done_m, cnt_tr[13]);
        end
    endtask

    task automatic test_midjob_reset;
        run_job(5'b11111, 1'b1, 8'd2, 8'hFF, 8'hFF, -1, 0, -1, 8, -1, 12);
        tests_run++;
        if (cnt_tr[8] !== 8'd2 || st_tr[8] !== 2'd2) begin
            tests_failed++;
            $display("FAIL rst_prejob: got cnt=%0d st=%0d want cnt=2 st=2", cnt_tr[8], st_tr[8]);
        end
        tests_run++;
        if (st_tr[9] !== 2'd0 || match_m[9] !== 1'b0 || cnt_tr[9] !== 8'd0 || bv_m[9] !== 1'b0 ||
            ir_m[9] !== 1'b0 || bo_m[9] !== 1'b0 || busy_m[9] !== 1'b0 || done_m[9] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_midjob: got st=%0d m=%b cnt=%0d bv=%b rdy=%b busy=%b done=%b want all 0",
                     st_tr[9], match_m[9], cnt_tr[9], bv_m[9], ir_m[9], busy_m[9], done_m[9]);
        end
    endtask

    // 40 words of ones give 320 bits and 316 overlapping matches; the counter stops at 255.
    task automatic test_saturation;
        run_job(5'b11111, 1'b1, 8'd40, 8'hFF, 8'hFF, -1, 0, -1, -1, -1, 370);
        tests_run++;
        if (last_cnt !== 8'd255 || n_match != 316 || done_seen != 1) begin
            tests_failed++;
            $display("FAIL saturation: got cnt=%0d pulses=%0d dones=%0d want cnt=255 pulses=316 dones=1",
                     last_cnt, n_match, done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_overlap_ones();
        test_nonoverlap_ones();
        test_cross_boundary();
        test_backpressure();
        test_zero_words();
        test_abort();
        test_midjob_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
